diabetes_mlp_seq: RTL and testbench

DIABETES_MLP_SEQ -- requirements
Module: diabetes_mlp_seq

---
 rtl/diabetes_mlp_seq_if.sv | 20 ++
 rtl/diabetes_mlp_seq.sv | 200 ++++++++++++++++++++
 tb/tb_diabetes_mlp_seq.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/diabetes_mlp_seq_if.sv
// Keypad, weight-load and display bundle between the front panel and the MLP classifier.
interface diabetes_mlp_seq_if #(parameter int N_DIG = 4);
  logic               CLEAR;
  logic               NEXT;
  logic               DIGIT_VALID;
  logic [3:0]         DIGIT;
  logic               W_WE;
  logic [7:0]         W_ADDR;
  logic [15:0]        W_DATA;
  logic [3:0]         DISP_IDX;
  logic [4*N_DIG-1:0] DISP_BCD;
  logic               BUSY;
  logic               DONE;
  logic [1:0]         RESULT;

  modport master (output CLEAR, NEXT, DIGIT_VALID, DIGIT, W_WE, W_ADDR, W_DATA,
                  input  DISP_IDX, DISP_BCD, BUSY, DONE, RESULT);
  modport slave  (input  CLEAR, NEXT, DIGIT_VALID, DIGIT, W_WE, W_ADDR, W_DATA,
                  output DISP_IDX, DISP_BCD, BUSY, DONE, RESULT);
endinterface

// File: rtl/diabetes_mlp_seq.sv
// Sequential MLP classifier: BCD feature entry, one shared MAC for the hidden and output
// layers, then a 4-way threshold classification shown on the display.
module diabetes_mlp_seq #(
  parameter int          N_FEAT = 6,
  parameter int          N_HID  = 7,
  parameter int          N_DIG  = 4,
  parameter int          FRAC   = 8,
  parameter logic [15:0] WINIT  = 16'h0011,
  parameter logic [31:0] T0     = 32'h6666,
  parameter logic [31:0] T1     = 32'h8000,
  parameter logic [31:0] T2     = 32'h9999
) (
  input logic               ADC_CLK_10,
  input logic               RESET_N,
  diabetes_mlp_seq_if.slave bus
);
  localparam int NW    = N_HID*(N_FEAT+1) + N_HID + 1;
  localparam int VBASE = N_HID*(N_FEAT+1);
  localparam int AW    = $clog2(NW);
  localparam int IW    = $clog2(N_FEAT+1);
  localparam int FI    = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam int HI    = (N_HID > 1) ? $clog2(N_HID) : 1;
  localparam int AB    = FRAC + 1;
  localparam logic signed [39:0] ONE = 40'sd1 <<< FRAC;

  typedef enum logic [2:0] {S_ENTRY, S_HB, S_HM, S_HA, S_OB, S_OM, S_CLS, S_SHOW} state_e;
  typedef logic [N_DIG-1:0][3:0] bcd_t;

  state_e                   state_q, state_d;
  logic [IW-1:0]            idx_q, idx_d;
  bcd_t [N_FEAT-1:0]        dig_q, dig_d;
  logic [HI-1:0]            h_q, h_d;
  logic [FI-1:0]            f_q, f_d;
  logic signed [39:0]       acc_q, acc_d;
  logic [N_HID-1:0][AB-1:0] a_q, a_d;
  logic [1:0]               res_q, res_d;
  logic                     done_q, done_d;
  logic [NW-1:0][15:0]      w_q;

  logic [AW-1:0]      waddr;
  logic [15:0]        wsel;
  logic [31:0]        xval;
  logic signed [39:0] wext;
  logic signed [47:0] xop, aop, wop, xprod, vprod;
  logic [AB-1:0]      relu;
  logic               we_ok;

  function automatic logic [31:0] bcd2bin(input bcd_t d);
    logic [31:0] v;
    v = '0;
    for (int i = N_DIG-1; i >= 0; i--) v = v*32'd10 + 32'(d[i]);
    return v;
  endfunction

  function automatic logic signed [39:0] sx32(input logic [31:0] t);
    return {{8{t[31]}}, t};
  endfunction

  // One weight port serves every compute state; the address follows the state.
  always_comb begin
    case (state_q)
      S_HB:    waddr = AW'(int'(h_q)*(N_FEAT+1) + N_FEAT);
      S_OB:    waddr = AW'(NW-1);
      S_OM:    waddr = AW'(VBASE + int'(h_q));
      default: waddr = AW'(int'(h_q)*(N_FEAT+1) + int'(f_q));
    endcase
  end

  assign wsel  = w_q[waddr];
  assign wext  = {{24{wsel[15]}}, wsel};
  assign xval  = bcd2bin(dig_q[f_q]);
  assign xop   = {16'b0, xval};
  assign aop   = {{(48-AB){1'b0}}, a_q[h_q]};
  assign wop   = {{32{wsel[15]}}, wsel};
  assign xprod = xop * wop;
  assign vprod = aop * wop;

  always_comb begin
    if (acc_q[39])        relu = '0;
    else if (acc_q > ONE) relu = AB'(ONE);
    else                  relu = acc_q[AB-1:0];
  end

  assign we_ok = bus.W_WE && (state_q == S_ENTRY || state_q == S_SHOW)
                 && ({24'b0, bus.W_ADDR} < 32'(NW));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dig_d   = dig_q;
    h_d     = h_q;
    f_d     = f_q;
    acc_d   = acc_q;
    a_d     = a_q;
    res_d   = res_q;
    done_d  = 1'b0;
    // NEXT while a result is shown behaves exactly like CLEAR.
    if (bus.CLEAR || (state_q == S_SHOW && bus.NEXT)) begin
      state_d = S_ENTRY;
      idx_d   = '0;
      dig_d   = '0;
    end else begin
      case (state_q)
        S_ENTRY: begin
          if (bus.NEXT) begin
            if (idx_q == IW'(N_FEAT-1)) begin
              state_d = S_HB;
              idx_d   = IW'(N_FEAT);
              h_d     = '0;
              f_d     = '0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else if (bus.DIGIT_VALID && bus.DIGIT <= 4'd9) begin
            dig_d[idx_q[FI-1:0]] = {dig_q[idx_q[FI-1:0]][N_DIG-2:0], bus.DIGIT};
          end
        end
        S_HB: begin
          acc_d   = wext;
          f_d     = '0;
          state_d = S_HM;
        end
        S_HM: begin
          acc_d = acc_q + xprod[39:0];
          if (f_q == FI'(N_FEAT-1)) begin
            f_d     = '0;
            state_d = S_HA;
          end else begin
            f_d = f_q + 1'b1;
          end
        end
        S_HA: begin
          a_d[h_q] = relu;
          if (h_q == HI'(N_HID-1)) begin
            state_d = S_OB;
          end else begin
            h_d     = h_q + 1'b1;
            state_d = S_HB;
          end
        end
        S_OB: begin
          acc_d   = wext <<< FRAC;
          h_d     = '0;
          state_d = S_OM;
        end
        S_OM: begin
          acc_d = acc_q + vprod[39:0];
          if (h_q == HI'(N_HID-1)) state_d = S_CLS;
          else                     h_d = h_q + 1'b1;
        end
        S_CLS: begin
          if (acc_q > sx32(T2))      res_d = 2'd3;
          else if (acc_q > sx32(T1)) res_d = 2'd2;
          else if (acc_q > sx32(T0)) res_d = 2'd1;
          else                       res_d = 2'd0;
          done_d  = 1'b1;
          state_d = S_SHOW;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge ADC_CLK_10) begin
    if (!RESET_N) begin
      state_q <= S_ENTRY;
      idx_q   <= '0;
      dig_q   <= '0;
      h_q     <= '0;
      f_q     <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
      w_q     <= {NW{WINIT}};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dig_q   <= dig_d;
      h_q     <= h_d;
      f_q     <= f_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      res_q   <= res_d;
      done_q  <= done_d;
      if (we_ok) w_q[bus.W_ADDR[AW-1:0]] <= bus.W_DATA;
    end
  end

  assign bus.DISP_IDX = 4'(idx_q);
  assign bus.BUSY     = (state_q != S_ENTRY) && (state_q != S_SHOW);
  assign bus.DONE     = done_q;
  assign bus.RESULT   = res_q;

  always_comb begin
    bus.DISP_BCD = '0;
    if (state_q == S_ENTRY && int'(idx_q) < N_FEAT) bus.DISP_BCD = dig_q[idx_q[FI-1:0]];
    else if (state_q == S_SHOW)                     bus.DISP_BCD = {{(4*N_DIG-2){1'b0}}, res_q};
  end
endmodule

// File: tb/tb_diabetes_mlp_seq.sv
// Scoreboarded bench for diabetes_mlp_seq: a feature/weight model predicts each class.
module tb_diabetes_mlp_seq;
  localparam int NF = 6;
  localparam int NH = 7;
  localparam int NW = NH*(NF+1) + NH + 1;

  typedef struct {
    logic [1:0] res;
    int         start;
  } exp_t;

  logic gclk = 1'b0;
  logic grst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  exp_t sb[$];

  logic [15:0] wm [NW];
  int          xm [NF];
  int          m_idx;

  always #5 gclk = ~gclk;
  always @(posedge gclk) cyc <= cyc + 1;

  diabetes_mlp_seq_if #(.N_DIG(4)) bus ();
  diabetes_mlp_seq dut (.ADC_CLK_10(gclk), .RESET_N(grst_n), .bus(bus));

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [1:0] model_class();
    longint y, acc, a;
    y = longint'($signed(wm[NW-1])) * 256;
    for (int h = 0; h < NH; h++) begin
      acc = longint'($signed(wm[h*(NF+1)+NF]));
      for (int f = 0; f < NF; f++)
        acc += longint'(xm[f]) * longint'($signed(wm[h*(NF+1)+f]));
      a = (acc < 0) ? 0 : ((acc > 256) ? 256 : acc);
      y += a * longint'($signed(wm[NH*(NF+1)+h]));
    end
    if (y > 39321)      return 2'd3;
    else if (y > 32768) return 2'd2;
    else if (y > 26214) return 2'd1;
    else                return 2'd0;
  endfunction

  task automatic model_clear();
    for (int f = 0; f < NF; f++) xm[f] = 0;
    m_idx = 0;
  endtask

  // One-cycle control pulse; the model applies CLEAR > NEXT > DIGIT priority.
  task automatic pulse(input bit c, input bit n, input bit dv, input logic [3:0] dg);
    bus.CLEAR = c; bus.NEXT = n; bus.DIGIT_VALID = dv; bus.DIGIT = dg;
    @(negedge gclk);
    bus.CLEAR = 1'b0; bus.NEXT = 1'b0; bus.DIGIT_VALID = 1'b0;
    if (c || (n && m_idx == NF)) model_clear();
    else if (m_idx < NF) begin
      if (n) m_idx++;
      else if (dv && dg <= 4'd9) xm[m_idx] = (xm[m_idx]*10 + int'(dg)) % 10000;
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    bus.W_WE = 1'b1; bus.W_ADDR = a; bus.W_DATA = d;
    @(negedge gclk);
    bus.W_WE = 1'b0;
    if (int'(a) < NW && m_idx < NF) wm[a] = d;
  endtask

  task automatic go(input bit push);
    while (m_idx < NF) pulse(1'b0, 1'b1, 1'b0, 4'd0);
    if (push) sb.push_back('{model_class(), cyc});
  endtask

  task automatic wait_done();
    for (int i = 0; i < 150 && sb.size() != 0; i++) @(negedge gclk);
    @(negedge gclk);
    if (sb.size() != 0) begin
      chk("done_timeout", 40'(sb.size()), 40'd0);
      sb.delete();
    end
  endtask

  task automatic enter148();
    pulse(1'b0, 1'b0, 1'b1, 4'd1);
    pulse(1'b0, 1'b0, 1'b1, 4'd4);
    pulse(1'b0, 1'b0, 1'b1, 4'd8);
  endtask

  always @(negedge gclk) begin
    if (bus.DONE === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_done", 40'd1, 40'd0);
      else begin
        chk("result", 40'(bus.RESULT), 40'(sb[0].res));
        chk("latency", 40'(cyc - sb[0].start), 40'd65);
        chk("show_bcd", 40'(bus.DISP_BCD), 40'(sb[0].res));
        chk("show_idx", 40'(bus.DISP_IDX), 40'(NF));
        chk("show_busy", 40'(bus.BUSY), 40'd0);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int v;
    bus.CLEAR = 0; bus.NEXT = 0; bus.DIGIT_VALID = 0; bus.DIGIT = 0;
    bus.W_WE = 0; bus.W_ADDR = 0; bus.W_DATA = 0;
    for (int i = 0; i < NW; i++) wm[i] = 16'h0011;
    model_clear();

    repeat (3) @(negedge gclk);
    chk("rst_idx", 40'(bus.DISP_IDX), 40'd0);
    chk("rst_bcd", 40'(bus.DISP_BCD), 40'd0);
    chk("rst_busy", 40'(bus.BUSY), 40'd0);
    chk("rst_done", 40'(bus.DONE), 40'd0);
    chk("rst_result", 40'(bus.RESULT), 40'd0);
    grst_n = 1'b1;
    @(negedge gclk);

    // Digit entry with MSD drop and invalid digit
    enter148();
    chk("bcd_148", 40'(bus.DISP_BCD), 40'h0148);
    pulse(0, 0, 1, 4'd2); pulse(0, 0, 1, 4'd3); pulse(0, 0, 1, 4'd4); pulse(0, 0, 1, 4'd5);
    chk("bcd_2345", 40'(bus.DISP_BCD), 40'h2345);
    pulse(0, 0, 1, 4'hA);
    chk("bcd_invalid", 40'(bus.DISP_BCD), 40'h2345);

    // Coincident pulses
    pulse(0, 1, 1, 4'd5);
    chk("next_wins_idx", 40'(bus.DISP_IDX), 40'd1);
    chk("next_wins_bcd", 40'(bus.DISP_BCD), 40'(to_bcd(xm[m_idx])));
    pulse(0, 0, 1, 4'd7);
    chk("feat1_bcd", 40'(bus.DISP_BCD), 40'h0007);
    pulse(1, 1, 1, 4'd3);
    chk("clear_wins_idx", 40'(bus.DISP_IDX), 40'd0);
    chk("clear_wins_bcd", 40'(bus.DISP_BCD), 40'h0000);
    pulse(0, 1, 0, 4'd0);
    chk("feat1_cleared", 40'(bus.DISP_BCD), 40'(to_bcd(xm[m_idx])));
    pulse(1, 0, 0, 4'd0);

    // All-zero features, default weights -> class 0
    go(1);
    chk("busy_start", 40'(bus.BUSY), 40'd1);
    wait_done();
    pulse(0, 1, 0, 4'd0);
    chk("show_next_idx", 40'(bus.DISP_IDX), 40'd0);
    chk("show_next_busy", 40'(bus.BUSY), 40'd0);

    // x0=148 saturates every hidden unit -> class 2, retained over CLEAR
    enter148();
    go(1);
    wait_done();
    pulse(1, 0, 0, 4'd0);
    chk("result_kept", 40'(bus.RESULT), 40'd2);
    chk("clear_idx", 40'(bus.DISP_IDX), 40'd0);
    chk("clear_bcd", 40'(bus.DISP_BCD), 40'd0);

    // Out-of-range write must not alias onto the output bias; then v[h]=0x20 -> class 3
    wr(8'h78, 16'h8000);
    for (int h = 0; h < NH; h++) wr(8'(NH*(NF+1)+h), 16'h0020);
    enter148();
    go(1);
    wait_done();
    pulse(1, 0, 0, 4'd0);

    // Write while busy is dropped; CLEAR at compute cycle 30 aborts with no DONE
    enter148();
    go(0);
    st = cyc;
    repeat (5) @(negedge gclk);
    chk("busy_mid", 40'(bus.BUSY), 40'd1);
    wr(8'(NW-1), 16'h8000);
    while (cyc - st < 29) @(negedge gclk);
    pulse(1, 0, 0, 4'd0);
    chk("abort_busy", 40'(bus.BUSY), 40'd0);
    chk("abort_idx", 40'(bus.DISP_IDX), 40'd0);
    chk("abort_done", 40'(bus.DONE), 40'd0);
    repeat (80) @(negedge gclk);
    enter148();
    go(1);
    wait_done();
    pulse(1, 0, 0, 4'd0);

    // Random small weights and two-digit features
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NW; i++) begin
        v = int'($urandom_range(0, 80)) - 40;
        wr(8'(i), 16'(v));
      end
      for (int f = 0; f < NF; f++) begin
        pulse(0, 0, 1, 4'($urandom_range(0, 9)));
        pulse(0, 0, 1, 4'($urandom_range(0, 9)));
        chk("rand_bcd", 40'(bus.DISP_BCD), 40'(to_bcd(xm[m_idx])));
        if (f < NF-1) pulse(0, 1, 0, 4'd0);
      end
      go(1);
      wait_done();
      pulse(1, 0, 0, 4'd0);
    end

    // Reset mid-compute with a concurrent weight write restores WINIT everywhere
    enter148();
    go(0);
    repeat (10) @(negedge gclk);
    grst_n = 1'b0;
    bus.W_WE = 1'b1; bus.W_ADDR = 8'd0; bus.W_DATA = 16'h8000;
    repeat (2) @(negedge gclk);
    bus.W_WE = 1'b0;
    chk("mid_rst_busy", 40'(bus.BUSY), 40'd0);
    chk("mid_rst_result", 40'(bus.RESULT), 40'd0);
    chk("mid_rst_idx", 40'(bus.DISP_IDX), 40'd0);
    grst_n = 1'b1;
    for (int i = 0; i < NW; i++) wm[i] = 16'h0011;
    model_clear();
    @(negedge gclk);
    enter148();
    go(1);
    wait_done();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
